// File: rtl/function_inverse_solver.sv
// Purpose: exhaustively searches the 16 input combinations {A,B,C,D} of a fixed
//   3-output boolean function for those whose output equals a requested target,
//   reporting the match count, the lowest matching index and (optionally) a match mask.
// Latency: done rises on the 17th rising edge after the edge that samples start.
// Backpressure: start is ignored while busy or while done is high; clr aborts a search.
// Ports: clk, rst_n (async active-low); start, clr, target[2:0] in;
//   busy, done, found, count[4:0], first_idx[3:0] out;
//   match_mask[15:0] out only when MATCH_MASK_EN is defined.
// Build option: MATCH_MASK_EN adds the per-index match mask port and register.
module function_inverse_solver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr,
  input  logic [2:0]  target,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [4:0]  count,
  output logic [3:0]  first_idx
`ifdef MATCH_MASK_EN
  ,
  output logic [15:0] match_mask
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [2:0]  tgt_q,   tgt_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        found_q, found_d;
  logic [3:0]  first_q, first_d;
  logic        done_q,  done_d;
`ifdef MATCH_MASK_EN
  logic [15:0] mask_q,  mask_d;
`endif

  // Function under inversion, evaluated on the current scan index.
  logic a, b, c, d;
  logic f_alpha, f_beta, f_gamma;
  logic hit;

  assign {a, b, c, d} = idx_q;

  always_comb begin
    f_alpha = (~a & ~c & d) | (a & ~c & d) | (b & c & d);
    f_beta  = (~a & ~b)     | (~a & ~c & d) | (b & c & d);
    f_gamma = (a & ~b)      | (a & ~c & d)  | (b & c & d);
    hit     = ({f_alpha, f_beta, f_gamma} == tgt_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    first_d = first_q;
    done_d  = 1'b0;
`ifdef MATCH_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        // done is high in the first IDLE cycle; a start seen then is held off
        // one cycle so the host always gets to read the results first.
        if (start && !done_q) begin
          state_d = SCAN;
          tgt_d   = target;
          idx_d   = 4'd0;
          cnt_d   = 5'd0;
          found_d = 1'b0;
          first_d = 4'd0;
`ifdef MATCH_MASK_EN
          mask_d  = 16'h0000;
`endif
        end
      end
      SCAN: begin
        if (clr) begin
          state_d = IDLE;
        end else begin
          if (hit) begin
            cnt_d = cnt_q + 5'd1;
            if (!found_q) begin
              found_d = 1'b1;
              first_d = idx_q;
            end
`ifdef MATCH_MASK_EN
            mask_d[idx_q] = 1'b1;
`endif
          end
          if (idx_q == 4'd15) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE: begin
        // The done pulse is registered, so it appears in the following IDLE cycle.
        state_d = IDLE;
        done_d  = !clr;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      tgt_q   <= 3'd0;
      cnt_q   <= 5'd0;
      found_q <= 1'b0;
      first_q <= 4'd0;
      done_q  <= 1'b0;
`ifdef MATCH_MASK_EN
      mask_q  <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      first_q <= first_d;
      done_q  <= done_d;
`ifdef MATCH_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign found     = found_q;
  assign count     = cnt_q;
  assign first_idx = first_q;
`ifdef MATCH_MASK_EN
  assign match_mask = mask_q;
`endif

endmodule

// File: tb/tb_function_inverse_solver.sv
module tb_function_inverse_solver;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic [2:0]  target;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  count;
  logic [3:0]  first_idx;
`ifdef MATCH_MASK_EN
  logic [15:0] match_mask;
`endif

  function_inverse_solver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .target    (target),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .count     (count),
    .first_idx (first_idx)
`ifdef MATCH_MASK_EN
    ,
    .match_mask(match_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  tgt;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic [15:0] mask;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] mask_obs;
`ifdef MATCH_MASK_EN
  assign mask_obs = match_mask;
`else
  assign mask_obs = 16'h0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits for done, counting rising edges after the start-sampling edge.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = k;
        break;
      end
    end
    if (edges == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_results();
    vec_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("found_t%0d", e.tgt), {31'd0, found}, {31'd0, (e.cnt != 5'd0)});
      check($sformatf("count_t%0d", e.tgt), {27'd0, count}, {27'd0, e.cnt});
      check($sformatf("first_t%0d", e.tgt), {28'd0, first_idx}, {28'd0, e.first});
`ifdef MATCH_MASK_EN
      check($sformatf("mask_t%0d", e.tgt), {16'd0, mask_obs}, {16'd0, e.mask});
`endif
    end
  endtask

  task automatic run_search(input logic [2:0] tgt);
    int edges;
    @(posedge clk); #1;
    target = tgt;
    start  = 1'b1;
    sb_q.push_back(vecs[tgt]);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(edges);
    check("done_edge", edges, 32'd17);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check_results();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_done"},  {31'd0, done},      32'd0);
    check({tag, "_found"}, {31'd0, found},     32'd0);
    check({tag, "_count"}, {27'd0, count},     32'd0);
    check({tag, "_first"}, {28'd0, first_idx}, 32'd0);
`ifdef MATCH_MASK_EN
    check({tag, "_mask"},  {16'd0, mask_obs},  32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sum_cnt;
    logic [15:0] or_mask;
    logic [15:0] ovl_mask;
    int          edges;
    int          done_cnt;

    // Expected results, tabulated by hand from the truth table of the function.
    vecs[0] = '{3'b000, 5'd4, 4'd4, 16'h5050};
    vecs[1] = '{3'b001, 5'd3, 4'd8, 16'h0D00};
    vecs[2] = '{3'b010, 5'd3, 4'd0, 16'h000D};
    vecs[3] = '{3'b011, 5'd0, 4'd0, 16'h0000};
    vecs[4] = '{3'b100, 5'd0, 4'd0, 16'h0000};
    vecs[5] = '{3'b101, 5'd2, 4'd9, 16'h2200};
    vecs[6] = '{3'b110, 5'd2, 4'd1, 16'h0022};
    vecs[7] = '{3'b111, 5'd2, 4'd7, 16'h8080};

    rst_n  = 1'b0;
    start  = 1'b0;
    clr    = 1'b0;
    target = 3'b000;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sweep every target, checking each result and the partition property.
    sum_cnt  = 0;
    or_mask  = 16'h0000;
    ovl_mask = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      run_search(vecs[i].tgt);
      sum_cnt  = sum_cnt + int'(count);
      ovl_mask = ovl_mask | (or_mask & mask_obs);
      or_mask  = or_mask | mask_obs;
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end
    check("sweep_count_sum", sum_cnt, 32'd16);
`ifdef MATCH_MASK_EN
    check("sweep_mask_or", {16'd0, or_mask}, 32'h0000FFFF);
    check("sweep_mask_overlap", {16'd0, ovl_mask}, 32'd0);
`endif

    // Results of the last search (target 111) hold while idle.
    repeat (5) @(posedge clk);
    #1;
    check("hold_count", {27'd0, count}, 32'd2);
    check("hold_first", {28'd0, first_idx}, 32'd7);

    // A start coinciding with done is deferred by one cycle.
    run_search(3'b010);
    target = 3'b000;
    start  = 1'b1;
    sb_q.push_back(vecs[0]);
    @(posedge clk); #1;
    check("start_blocked_by_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_after_done", {31'd0, busy}, 32'd1);
    wait_done(edges);
    check("deferred_done_edge", edges, 32'd17);
    check_results();

    // Target change and start pulse mid-scan have no effect.
    @(posedge clk); #1;
    target = 3'b101;
    start  = 1'b1;
    sb_q.push_back(vecs[5]);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    target = 3'b001;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        check_results();
      end
    end
    check("midscan_done_pulses", done_cnt, 32'd1);

    // clr during the 5th scan cycle: back to idle, no done.
    @(posedge clk); #1;
    target = 3'b010;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("clr_no_done", done_cnt, 32'd0);

    // Asynchronous reset mid-scan clears everything immediately.
    @(posedge clk); #1;
    target = 3'b010;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_search(3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/function_inverse_solver.md
FUNCTION_INVERSE_SOLVER -- requirements
Module: function_inverse_solver

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a search; sampled only in IDLE.
REQ-004 SHALL have port clr, input, 1 bit: synchronous abort of a running search.
REQ-005 SHALL have port target, input, 3 bits: wanted output pattern {Falpha,Fbeta,Fgamma}, Falpha in the MSB.
REQ-006 SHALL have port busy, output, 1 bit: search in progress (SCAN or DONE).
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-008 SHALL have port found, output, 1 bit: at least one input combination matched.
REQ-009 SHALL have port count, output, 5 bits: number of matching input combinations (0..16).
REQ-010 SHALL have port first_idx, output, 4 bits: lowest matching index {A,B,C,D}, A in the MSB.
REQ-011 SHALL have port match_mask, output, 16 bits: bit i set when index i matched; present only when MATCH_MASK_EN is defined.

Function
REQ-012 SHALL evaluate, internally and combinationally, Falpha = A'C'D + AC'D + BCD, Fbeta = A'B' + A'C'D + BCD, Fgamma = AB' + AC'D + BCD, with {A,B,C,D} = scan index.
REQ-013 SHALL implement states IDLE, SCAN and DONE, in IDLE after reset.
REQ-014 SHALL, in IDLE with start=1, latch target, clear count/found/first_idx/match_mask, zero the index and enter SCAN.
REQ-015 SHALL, in SCAN, evaluate one index per cycle, ascending from 0 to 15 (16 cycles).
REQ-016 SHALL, on a match, increment count and set match_mask bit i; first_idx and found are loaded on the first match only.
REQ-017 SHALL, after index 15 is evaluated, enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-018 SHALL assert done on the 17th rising edge after the edge that sampled start.
REQ-019 SHALL hold busy=1 in SCAN and DONE, and 0 in IDLE.
REQ-020 SHALL ignore start while busy=1, and SHALL NOT change the latched target mid-search.
REQ-021 SHALL hold results (found, count, first_idx, match_mask) stable from done until the next accepted start.
REQ-022 SHALL, with no match, report found=0, count=0, first_idx=0 and match_mask=0.
REQ-023 SHALL, on clr=1 in SCAN or DONE, return to IDLE next edge with done=0 and no done pulse; partial results are left undefined-free at their current values; clr SHALL take priority over start.
REQ-024 SHALL, with start=1 in the same cycle done=1, not accept that start; it is accepted in the following IDLE cycle.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force IDLE, busy=0, done=0, found=0, count=0, first_idx=0, match_mask=0, latched target=0 and index=0.
REQ-026 SHALL, on reset mid-search, abandon the search without a done pulse; the first start after reset release begins a fresh search.

Configuration
REQ-027 SHALL, with MATCH_MASK_EN defined, include the 16-bit match_mask port and register.
REQ-028 SHALL, without MATCH_MASK_EN, omit the match_mask port and register entirely, leaving all other behaviour and timing unchanged.

Verification
REQ-029 SHALL cover: reset, then start with target=3'b010 -> done at edge 17, found=1, count=3, first_idx=0, match_mask=16'h000D.
REQ-030 SHALL cover: target=3'b000 -> count=4, first_idx=4, match_mask=16'h5050; target=3'b111 -> count=2, first_idx=7, match_mask=16'h8080.
REQ-031 SHALL cover: target=3'b011 and target=3'b100 -> found=0, count=0, first_idx=0, match_mask=0.
REQ-032 SHALL cover: target=3'b101, with target changed to 3'b001 and start pulsed during SCAN -> results stay count=2, first_idx=9, match_mask=16'h2200, and exactly one done pulse.
REQ-033 SHALL cover: clr on the 5th SCAN cycle -> IDLE next edge, no done; rst_n low during SCAN -> all outputs 0 immediately.
REQ-034 SHALL cover: a sweep of all 8 targets -> the count values sum to 16 and the match_mask values OR to 16'hFFFF with no overlap.
